// File: rtl/alu_instr_sequencer_if.sv
// Purpose: Control and readback bundle between the instruction sequencer and the
//          Phase-1 Datapath.
// Ports (signals):
//   run, ir            - Datapath/host -> sequencer: run level and latched IR
//   PCout..LOin        - sequencer -> Datapath: single-bit control strobes
//   Rout, Rin          - one-hot register bus-drive / bus-load enables (bit n = Rn)
//   opcode             - ALU operation select
//   busy, done, illegal, instr_count - sequencer status
interface alu_instr_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run;
    logic [31:0]      ir;
    logic             PCout;
    logic             PCin;
    logic             IncPC;
    logic             MARin;
    logic             MDRin;
    logic             MDRout;
    logic             Read;
    logic             IRin;
    logic             Yin;
    logic             Zin;
    logic             Zlowout;
    logic             Zhighout;
    logic             HIin;
    logic             LOin;
    logic [15:0]      Rout;
    logic [15:0]      Rin;
    logic [4:0]       opcode;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    // Sequencer side.
    modport master (
        input  run, ir,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
               Zlowout, Zhighout, HIin, LOin, Rout, Rin, opcode,
               busy, done, illegal, instr_count
    );

    // Datapath / host side.
    modport slave (
        output run, ir,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
               Zlowout, Zhighout, HIin, LOin, Rout, Rin, opcode,
               busy, done, illegal, instr_count
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Purpose: Hard-wired Moore control unit sequencing the Phase-1 Datapath through
//          fetch (T0-T2) and execute (T3-T6) for register ALU ops, mul, div and nop.
// Ports:
//   clock - rising-edge clock
//   clear - synchronous active-high reset (priority over everything)
//   bus   - alu_instr_sequencer_if.master: run/ir in, strobes/enables/status out
// Strobes, Rout/Rin, opcode, busy, done and illegal decode from state + ir only;
// the state and the retired-instruction counter are the only flops.
module alu_instr_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    alu_instr_sequencer_if.master bus
);
    localparam logic [4:0] NOP_OP     = 5'b01101;
    localparam logic [4:0] MUL_OP     = 5'b01111;
    localparam logic [4:0] DIV_OP     = 5'b10000;
    localparam logic [4:0] ALU_MAX_OP = 5'b01100;

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_muldiv, is_nop;
    logic       last_step;
    logic       unused_ir_bits;

    // IR field decode; only meaningful from T3 on, once IR has been loaded.
    assign op             = bus.ir[31:27];
    assign ra             = bus.ir[26:23];
    assign rb             = bus.ir[22:19];
    assign rc             = bus.ir[18:15];
    assign unused_ir_bits = ^bus.ir[14:0];

    assign is_alu    = (op <= ALU_MAX_OP);
    assign is_muldiv = (op == MUL_OP) || (op == DIV_OP);
    assign is_nop    = (op == NOP_OP);

    assign bus.instr_count = count_q;

    // State and retired-instruction counter.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d      = state_q;
        last_step    = 1'b0;
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Read     = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Rout     = '0;
        bus.Rin      = '0;
        bus.opcode   = NOP_OP;
        bus.illegal  = 1'b0;
        bus.busy     = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_T0;
            end
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                state_d   = S_T1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                state_d     = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = S_T3;
            end
            S_T3: begin
                if (is_alu || is_muldiv) begin
                    bus.Rout = 16'(1) << ra;
                    bus.Yin  = 1'b1;
                    state_d  = S_T4;
                end else begin
                    // nop and unsupported opcodes retire here
                    bus.illegal = !is_nop;
                    last_step   = 1'b1;
                end
            end
            S_T4: begin
                bus.Rout   = 16'(1) << rb;
                bus.Zin    = 1'b1;
                bus.opcode = op;
                state_d    = S_T5;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (is_muldiv) begin
                    bus.LOin = 1'b1;
                    state_d  = S_T6;
                end else begin
                    bus.Rin   = 16'(1) << rc;
                    last_step = 1'b1;
                end
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                last_step    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // run is only looked at on the retiring step; no bubble between instructions
        if (last_step) state_d = bus.run ? S_T0 : S_IDLE;

        bus.done = last_step;
        count_d  = last_step ? count_q + CNT_W'(1) : count_q;
    end
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed testbench for alu_instr_sequencer: per-cycle strobe/enable vectors for
// div, ALU, nop, illegal, clear mid-instruction, run drop, and counter wrap (on a
// narrow-counter second instance).
module tb_alu_instr_sequencer;
    localparam logic [13:0] PCOUT    = 14'h2000;
    localparam logic [13:0] PCIN     = 14'h1000;
    localparam logic [13:0] INCPC    = 14'h0800;
    localparam logic [13:0] MARIN    = 14'h0400;
    localparam logic [13:0] MDRIN    = 14'h0200;
    localparam logic [13:0] MDROUT   = 14'h0100;
    localparam logic [13:0] READ     = 14'h0080;
    localparam logic [13:0] IRIN     = 14'h0040;
    localparam logic [13:0] YIN      = 14'h0020;
    localparam logic [13:0] ZIN      = 14'h0010;
    localparam logic [13:0] ZLOWOUT  = 14'h0008;
    localparam logic [13:0] ZHIGHOUT = 14'h0004;
    localparam logic [13:0] HIIN     = 14'h0002;
    localparam logic [13:0] LOIN     = 14'h0001;
    localparam logic [13:0] F0 = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [13:0] F1 = ZLOWOUT | PCIN | READ | MDRIN;
    localparam logic [13:0] F2 = MDROUT | IRIN;

    localparam logic [4:0]  NOP    = 5'b01101;
    localparam logic [31:0] DIV_IR = 32'h82280000;  // div R4,R5
    localparam logic [31:0] ALU_IR = 32'h18918000;  // op 00011 R1,R2,R3
    localparam logic [31:0] NOP_IR = 32'h68000000;
    localparam logic [31:0] ILL_IR = 32'h70000000;  // opcode 01110

    logic clock;
    logic clear;
    logic clear_w;
    int   vectors;
    int   miscompares;

    alu_instr_sequencer_if #(.CNT_W(16)) bus_if ();
    alu_instr_sequencer_if #(.CNT_W(3))  w_if ();

    alu_instr_sequencer #(.CNT_W(16)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus_if.master)
    );

    alu_instr_sequencer #(.CNT_W(3)) dut_w (
        .clock (clock),
        .clear (clear_w),
        .bus   (w_if.master)
    );

    logic [53:0] obs;
    assign obs = {bus_if.PCout, bus_if.PCin, bus_if.IncPC, bus_if.MARin, bus_if.MDRin,
                  bus_if.MDRout, bus_if.Read, bus_if.IRin, bus_if.Yin, bus_if.Zin,
                  bus_if.Zlowout, bus_if.Zhighout, bus_if.HIin, bus_if.LOin,
                  bus_if.Rout, bus_if.Rin, bus_if.opcode,
                  bus_if.busy, bus_if.done, bus_if.illegal};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [53:0] ev(input logic [13:0] s, input logic [15:0] ro,
                                       input logic [15:0] ri, input logic [4:0] opc,
                                       input logic b, input logic d, input logic il);
        return {s, ro, ri, opc, b, d, il};
    endfunction

    localparam logic [53:0] IDLE_V = {14'h0, 16'h0, 16'h0, 5'b01101, 3'b000};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        clear_w = 1'b1;
        tick();
        tick();
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want %h", obs, IDLE_V);
        end
        vectors++;
        if (bus_if.instr_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %h want 0000", bus_if.instr_count);
        end
        clear = 1'b0;
        clear_w = 1'b0;
        tick();
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL idle_hold: got %h want %h", obs, IDLE_V);
        end
    endtask

    task automatic test_div();
        logic [53:0] e[$];
        e.push_back(ev(F0, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F1, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F2, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(YIN, 16'h0010, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(ZIN, 16'h0020, 16'h0, 5'b10000, 1, 0, 0));
        e.push_back(ev(ZLOWOUT | LOIN, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(ZHIGHOUT | HIIN, 16'h0, 16'h0, NOP, 1, 1, 0));
        e.push_back(IDLE_V);
        bus_if.ir = DIV_IR;
        bus_if.run = 1'b1;
        foreach (e[i]) begin
            tick();
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL div step %0d: got %h want %h", i, obs, e[i]);
            end
            if (i == 6) bus_if.run = 1'b0;
        end
        vectors++;
        if (bus_if.instr_count !== 16'd1) begin
            miscompares++;
            $display("FAIL div_count: got %h want 0001", bus_if.instr_count);
        end
    endtask

    task automatic test_alu();
        logic [53:0] e[$];
        e.push_back(ev(F0, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F1, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F2, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(YIN, 16'h0002, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(ZIN, 16'h0004, 16'h0, 5'b00011, 1, 0, 0));
        e.push_back(ev(ZLOWOUT, 16'h0, 16'h0008, NOP, 1, 1, 0));
        e.push_back(IDLE_V);
        bus_if.ir = ALU_IR;
        bus_if.run = 1'b1;
        foreach (e[i]) begin
            tick();
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL alu step %0d: got %h want %h", i, obs, e[i]);
            end
            if (i == 5) bus_if.run = 1'b0;
        end
        vectors++;
        if (bus_if.instr_count !== 16'd2) begin
            miscompares++;
            $display("FAIL alu_count: got %h want 0002", bus_if.instr_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [53:0] e[$];
        e.push_back(ev(F0, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F1, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F2, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(14'h0, 16'h0, 16'h0, NOP, 1, 1, 0));
        e.push_back(ev(F0, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F1, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F2, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(14'h0, 16'h0, 16'h0, NOP, 1, 1, 1));
        e.push_back(IDLE_V);
        bus_if.ir = NOP_IR;
        bus_if.run = 1'b1;
        foreach (e[i]) begin
            tick();
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL nop_illegal step %0d: got %h want %h", i, obs, e[i]);
            end
            if (i == 3) bus_if.ir = ILL_IR;
            if (i == 7) bus_if.run = 1'b0;
        end
        vectors++;
        if (bus_if.instr_count !== 16'd4) begin
            miscompares++;
            $display("FAIL nop_illegal_count: got %h want 0004", bus_if.instr_count);
        end
    endtask

    task automatic test_clear_mid();
        logic [53:0] e[$];
        e.push_back(ev(F0, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F1, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F2, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(YIN, 16'h0010, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(ZIN, 16'h0020, 16'h0, 5'b10000, 1, 0, 0));
        e.push_back(IDLE_V);
        e.push_back(IDLE_V);
        e.push_back(IDLE_V);
        bus_if.ir = DIV_IR;
        bus_if.run = 1'b1;
        foreach (e[i]) begin
            tick();
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL clear_mid step %0d: got %h want %h", i, obs, e[i]);
            end
            if (i == 4) clear = 1'b1;
            if (i == 6) begin
                clear = 1'b0;
                bus_if.run = 1'b0;
            end
        end
        vectors++;
        if (bus_if.instr_count !== 16'd0) begin
            miscompares++;
            $display("FAIL clear_mid_count: got %h want 0000", bus_if.instr_count);
        end
    endtask

    task automatic test_run_drop();
        logic [53:0] e[$];
        e.push_back(ev(F0, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F1, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(F2, 16'h0, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(YIN, 16'h0002, 16'h0, NOP, 1, 0, 0));
        e.push_back(ev(ZIN, 16'h0004, 16'h0, 5'b00011, 1, 0, 0));
        e.push_back(ev(ZLOWOUT, 16'h0, 16'h0008, NOP, 1, 1, 0));
        e.push_back(IDLE_V);
        e.push_back(IDLE_V);
        bus_if.ir = ALU_IR;
        bus_if.run = 1'b1;
        foreach (e[i]) begin
            tick();
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL run_drop step %0d: got %h want %h", i, obs, e[i]);
            end
            if (i == 1) bus_if.run = 1'b0;
        end
        vectors++;
        if (bus_if.instr_count !== 16'd1) begin
            miscompares++;
            $display("FAIL run_drop_count: got %h want 0001", bus_if.instr_count);
        end
    endtask

    // 3-bit counter: count reaches all-ones after 7 nops, then wraps to 0 and 1.
    task automatic test_count_wrap();
        w_if.ir = NOP_IR;
        w_if.run = 1'b1;
        for (int n = 1; n <= 37; n++) begin
            tick();
            if (n == 29) begin
                vectors++;
                if (w_if.instr_count !== 3'd7) begin
                    miscompares++;
                    $display("FAIL wrap_max: got %h want 7", w_if.instr_count);
                end
            end
            if (n == 33) begin
                vectors++;
                if (w_if.instr_count !== 3'd0) begin
                    miscompares++;
                    $display("FAIL wrap_zero: got %h want 0", w_if.instr_count);
                end
            end
            if (n == 37) begin
                vectors++;
                if (w_if.instr_count !== 3'd1) begin
                    miscompares++;
                    $display("FAIL wrap_one: got %h want 1", w_if.instr_count);
                end
            end
        end
        w_if.run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        clear = 1'b1;
        clear_w = 1'b1;
        bus_if.run = 1'b0;
        bus_if.ir = '0;
        w_if.run = 1'b0;
        w_if.ir = '0;
        test_reset();
        test_div();
        test_alu();
        test_back_to_back();
        test_clear_mid();
        test_run_drop();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
